// File: rtl/t_vpi_chg_log_pkg.sv
// Shared types and constants for the value-change logger.
package t_vpi_chg_log_pkg;

    localparam int CHG_W    = 32;
    localparam int CHG_TS_W = 32;
    localparam int DROP_MAX = 255;

    // One logged change: the new bus value and the cycle it was seen on.
    typedef struct packed {
        logic [CHG_W-1:0]    value;
        logic [CHG_TS_W-1:0] ts;
    } chg_entry_t;

endpackage

// File: rtl/t_vpi_chg_log_fifo.sv
// Synchronous FIFO for the change logger. A push into a full FIFO is
// ignored unless a pop happens in the same cycle; pop on empty is ignored.
// The head reads zero while empty.
module t_vpi_chg_log_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/t_vpi_chg_log.sv
// Value-change logger: detects changes on a watched bus and queues them,
// with a cycle timestamp, for a host monitor to read and pop.
// Build option: define CHG_LOG_TS_EN to include the cycle counter and
// per-entry timestamps; otherwise head_ts and cycle read as 0.
module t_vpi_chg_log
    import t_vpi_chg_log_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic [WIDTH-1:0]    watch,
    input  logic                pop_req,
    output logic                head_valid,
    output logic [WIDTH-1:0]    head_value,
    output logic [TS_WIDTH-1:0] head_ts,
    output logic [LW-1:0]       level,
    output logic [TS_WIDTH-1:0] cycle,
    output logic                overflow,
    output logic [7:0]          drop_count
);

`ifdef CHG_LOG_TS_EN
    localparam int DW = WIDTH + TS_WIDTH;
`else
    localparam int DW = WIDTH;
`endif

    logic [WIDTH-1:0] prev;
    logic             armed;
    logic             change;
    logic             full;
    logic             empty;
    logic             drop;
    logic [DW-1:0]    din;
    logic [DW-1:0]    head;

    // Nothing is compared until the arm cycle has reloaded prev after reset.
    assign change = armed && (watch != prev);
    // Full implies non-empty, so any pop_req frees a slot for the push.
    assign drop   = change && full && !pop_req;

    // Previous-value register and arm flag.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            prev  <= watch;
            armed <= 1'b0;
        end else begin
            prev  <= watch;
            armed <= 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'(DROP_MAX)) drop_count <= drop_count + 1'b1;
        end
    end

`ifdef CHG_LOG_TS_EN
    logic [TS_WIDTH-1:0] cyc_q;

    // Free-running cycle counter, started by the arm cycle; wraps modulo.
    always_ff @(posedge clk) begin
        if (!reset_l)   cyc_q <= '0;
        else if (armed) cyc_q <= cyc_q + 1'b1;
    end

    assign din        = {watch, cyc_q};
    assign head_value = head[DW-1 -: WIDTH];
    assign head_ts    = head[TS_WIDTH-1:0];
    assign cycle      = cyc_q;
`else
    assign din        = watch;
    assign head_value = head;
    assign head_ts    = '0;
    assign cycle      = '0;
`endif

    assign head_valid = !empty;

    t_vpi_chg_log_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (change),
        .pop     (pop_req),
        .din     (din),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_t_vpi_chg_log.sv
// Bench for t_vpi_chg_log: directed table, corner sequences and random
// traffic checked every cycle against a queue-based model.
module tb_t_vpi_chg_log;
    import t_vpi_chg_log_pkg::*;

`ifdef CHG_LOG_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        reset_l = 0;
    logic [31:0] watch = 0;
    logic        pop_req = 0;
    logic        head_valid;
    logic [31:0] head_value;
    logic [31:0] head_ts;
    logic [3:0]  level;
    logic [31:0] cycle;
    logic        overflow;
    logic [7:0]  drop_count;

    t_vpi_chg_log dut (
        .clk(clk), .reset_l(reset_l), .watch(watch), .pop_req(pop_req),
        .head_valid(head_valid), .head_value(head_value), .head_ts(head_ts),
        .level(level), .cycle(cycle), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    chg_entry_t  q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_prev;
    bit          m_armed;
    bit          m_ovf;
    int          m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit chg;
        if (!reset_l) begin
            q.delete();
            m_cyc = 0; m_ovf = 0; m_drops = 0; m_armed = 0; m_prev = watch;
        end else if (!m_armed) begin
            m_armed = 1; m_prev = watch;
        end else begin
            chg = (watch != m_prev);
            m_prev = watch;
            if (pop_req && q.size() > 0) void'(q.pop_front());
            if (chg) begin
                if (q.size() < DEPTH) q.push_back('{value: watch, ts: (TS_EN ? m_cyc : 32'd0)});
                else begin
                    m_ovf = 1;
                    if (m_drops < DROP_MAX) m_drops++;
                end
            end
            m_cyc = m_cyc + 1;
        end
    endtask

    task automatic model_check();
        chk("m_valid", 64'(head_valid), 64'(q.size() > 0));
        chk("m_level", 64'(level), 64'(q.size()));
        chk("m_value", 64'(head_value), (q.size() > 0) ? 64'(q[0].value) : 64'd0);
        chk("m_ts", 64'(head_ts), (q.size() > 0) ? 64'(q[0].ts) : 64'd0);
        chk("m_cycle", 64'(cycle), TS_EN ? 64'(m_cyc) : 64'd0);
        chk("m_ovf", 64'(overflow), 64'(m_ovf));
        chk("m_drops", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic tick(input logic r, input logic [31:0] w, input logic p);
        reset_l = r; watch = w; pop_req = p;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic        r;
        logic [31:0] w;
        logic        p;
        logic        e_valid;
        logic [3:0]  e_level;
        logic [31:0] e_value;
        logic [31:0] e_ts;
        logic [31:0] e_cycle;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};  // reset
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};  // arm, no log
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 2};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 3};
        tbl[5]  = '{1, 5, 0, 1, 1, 5, 3, 4};  // change logged at ts 3
        tbl[6]  = '{1, 5, 1, 0, 0, 0, 0, 5};  // pop to empty
        tbl[7]  = '{1, 7, 1, 1, 1, 7, 5, 6};  // push+pop on empty: push wins
        tbl[8]  = '{1, 7, 1, 0, 0, 0, 0, 7};
        tbl[9]  = '{0, 7, 0, 0, 0, 0, 0, 0};  // reset
        tbl[10] = '{1, 9, 0, 0, 0, 0, 0, 0};  // arm ignores changed watch
        tbl[11] = '{1, 9, 0, 0, 0, 0, 0, 1};

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].r, tbl[i].w, tbl[i].p);
            chk($sformatf("tbl%0d_valid", i), 64'(head_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].e_level));
            chk($sformatf("tbl%0d_value", i), 64'(head_value), 64'(tbl[i].e_value));
            chk($sformatf("tbl%0d_ts", i), 64'(head_ts), TS_EN ? 64'(tbl[i].e_ts) : 64'd0);
            chk($sformatf("tbl%0d_cycle", i), 64'(cycle), TS_EN ? 64'(tbl[i].e_cycle) : 64'd0);
        end

        // Constant watch for 20 cycles after arm: nothing logged
        tick(0, 3, 0); tick(1, 3, 0);
        for (int i = 0; i < 20; i++) tick(1, 3, 0);
        chk("idle_valid", 64'(head_valid), 64'd0);
        chk("idle_cycle", 64'(cycle), TS_EN ? 64'd20 : 64'd0);
        chk("idle_ovf", 64'(overflow), 64'd0);

        // 12 changes, no pops: 8 stored, 4 dropped
        tick(0, 0, 0); tick(1, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 32'(i + 1), 0);
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_drops", 64'(drop_count), 64'd4);
        chk("fill_head", 64'(head_value), 64'd1);

        // Full FIFO, push and pop together: no drop
        tick(0, 0, 0); tick(1, 0, 0);
        for (int i = 0; i < 8; i++) tick(1, 32'(i + 1), 0);
        tick(1, 100, 1);
        chk("fullpp_level", 64'(level), 64'd8);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        chk("fullpp_head", 64'(head_value), 64'd2);

        // Pop held on empty, then one change
        tick(0, 0, 0); tick(1, 0, 1);
        for (int i = 0; i < 5; i++) tick(1, 0, 1);
        chk("pe_level0", 64'(level), 64'd0);
        tick(1, 3, 1);
        chk("pe_visible", 64'(head_value), 64'd3);
        chk("pe_level1", 64'(level), 64'd1);
        tick(1, 3, 1);
        chk("pe_consumed", 64'(level), 64'd0);
        tick(1, 3, 1);
        chk("pe_no_underflow", 64'(level), 64'd0);

        // Reset mid-operation with 5 queued
        tick(0, 0, 0); tick(1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 32'(i + 1), 0);
        chk("mr_level5", 64'(level), 64'd5);
        tick(0, 5, 0);
        chk("mr_valid", 64'(head_valid), 64'd0);
        chk("mr_value", 64'(head_value), 64'd0);
        chk("mr_level", 64'(level), 64'd0);
        tick(1, 42, 0);
        chk("mr_arm_nolog", 64'(level), 64'd0);

        // Drop counter saturation
        tick(0, 0, 0); tick(1, 0, 0);
        for (int i = 0; i < 300; i++) tick(1, 32'(i + 1), 0);
        chk("sat_drops", 64'(drop_count), 64'd255);
        chk("sat_head", 64'(head_value), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            tick(logic'($urandom_range(0, 99) != 0), 32'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 2) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
